// File: rtl/aixh_mxc_bwd_collect_pkg.sv
// ---------------------------------------------------------------------------
// AIXH_MXC_pkg
// Shared constants and types for the MXC backward result collector.
//   MXC_YCOUNT / MXC_YCELLS / MXC_CELL_DW : default array geometry and
//                                           result-cell width
//   MXC_NCELL                              : cells in one aligned word
//   STAT_W                                 : width of the statistics counters
//   mxc_res_t                              : aligned result word {msk, dat};
//                                           the collector's FIFO word uses
//                                           the same bit layout
// ---------------------------------------------------------------------------
package AIXH_MXC_pkg;

    localparam int MXC_YCOUNT  = 4;
    localparam int MXC_YCELLS  = 4;
    localparam int MXC_CELL_DW = 32;
    localparam int MXC_NCELL   = MXC_YCOUNT * MXC_YCELLS;
    localparam int STAT_W      = 32;

    // Mask sits above the data so {msk, dat} packs the same way the
    // collector concatenates its FIFO word.
    typedef struct packed {
        logic [MXC_NCELL-1:0]             msk;
        logic [MXC_NCELL*MXC_CELL_DW-1:0] dat;
    } mxc_res_t;

endpackage

// File: rtl/aixh_mxc_bwd_collect_fifo.sv
// ---------------------------------------------------------------------------
// aixh_mxc_bwd_fifo
// First-word-fall-through buffer for aligned result words.
//   clock_i, reset_i : clock, asynchronous active-high reset
//   pushVld_i        : write request; pushDat_i is the word to store
//   popRdy_i         : consumer takes the head word when popVld_o is high
//   popVld_o         : buffer not empty; popDat_o is the head word (zero
//                      while empty)
//   afull_o          : occupancy >= AFULL_TH
//   drop_o           : write request refused because the buffer was full
//                      and nothing left in the same cycle
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module aixh_mxc_bwd_fifo
    import AIXH_MXC_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             pushVld_i,
    input  logic [WIDTH-1:0] pushDat_i,
    input  logic             popRdy_i,
    output logic             popVld_o,
    output logic [WIDTH-1:0] popDat_o,
    output logic             afull_o,
    output logic             drop_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic pop;
    logic pushAcc;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = !empty && popRdy_i;
    // A pop in the same cycle frees the slot, so a full buffer still
    // accepts the write.
    assign pushAcc = pushVld_i && (!full || pop);
    assign drop_o  = pushVld_i && full && !pop;

    assign popVld_o = !empty;
    assign popDat_o = empty ? '0 : mem_q[rdPtr_q];
    assign afull_o  = (count_q >= CNT_W'(AFULL_TH));

    // Pointer and occupancy next-state.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushAcc) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({pushAcc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the read side only exposes it while the
    // occupancy says it holds valid words.
    always_ff @(posedge clock_i) begin
        if (pushAcc) begin
            mem_q[wrPtr_q] <= pushDat_i;
        end
    end

endmodule

// File: rtl/aixh_mxc_bwd_collect.sv
// ---------------------------------------------------------------------------
// aixh_mxc_bwd_collect
// Deskews the per-row backward results leaving the array's west edge into
// one aligned word per wavefront and buffers those words for the consumer.
//   aixh_core_clk2x / aixh_core_rst2x : clock, async active-high reset
//   i_bwd_vld / i_bwd_dat             : per-cell valids/data, row y at
//                                       [YCELLS*y +: YCELLS]
//   i_clr                             : clears sticky overflow (and stats)
//   o_res_vld / i_res_rdy             : FWFT valid/ready handshake
//   o_res_dat / o_res_msk             : aligned word and its cell mask
//   o_afull                           : occupancy >= FIFO_DEPTH-YCOUNT
//   o_ovf                             : sticky, a word was dropped
// Optional: define AIXH_MXC_BWD_COLLECT_STAT_EN to add saturating
// o_stat_push / o_stat_drop word counters.
// ---------------------------------------------------------------------------
module aixh_mxc_bwd_collect
    import AIXH_MXC_pkg::*;
#(
    parameter int YCOUNT     = MXC_YCOUNT,
    parameter int YCELLS     = MXC_YCELLS,
    parameter int CELL_DW    = MXC_CELL_DW,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              aixh_core_clk2x,
    input  logic                              aixh_core_rst2x,
    input  logic [YCOUNT*YCELLS-1:0]          i_bwd_vld,
    input  logic [YCOUNT*YCELLS*CELL_DW-1:0]  i_bwd_dat,
    input  logic                              i_clr,
    output logic                              o_res_vld,
    input  logic                              i_res_rdy,
    output logic [YCOUNT*YCELLS*CELL_DW-1:0]  o_res_dat,
    output logic [YCOUNT*YCELLS-1:0]          o_res_msk,
    output logic                              o_afull,
    output logic                              o_ovf
`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
    ,
    output logic [STAT_W-1:0]                 o_stat_push,
    output logic [STAT_W-1:0]                 o_stat_drop
`endif
);

    localparam int NCELL  = YCOUNT * YCELLS;
    localparam int ROW_DW = YCELLS * CELL_DW;
    localparam int WORD_W = NCELL + NCELL * CELL_DW;

    logic [NCELL-1:0]         alignVld;
    logic [NCELL*CELL_DW-1:0] alignDatRaw;
    logic [NCELL*CELL_DW-1:0] alignDat;
    logic                     pushVld;
    logic [WORD_W-1:0]        rdWord;
    logic                     fifoDrop;
    logic                     ovf_q, ovf_d;

    // Row y leaves the array y cycles behind row 0, so it is held for
    // YCOUNT-1-y cycles; the last row feeds the aligned word directly,
    // which puts the push on the edge closing the cycle that row arrives.
    for (genvar y = 0; y < YCOUNT; y++) begin : gRow
        localparam int DLY = YCOUNT - 1 - y;
        if (DLY == 0) begin : gDirect
            assign alignVld[YCELLS*y +: YCELLS]    = i_bwd_vld[YCELLS*y +: YCELLS];
            assign alignDatRaw[ROW_DW*y +: ROW_DW] = i_bwd_dat[ROW_DW*y +: ROW_DW];
        end else begin : gDelay
            logic [YCELLS-1:0] vldPipe_q [DLY];
            logic [ROW_DW-1:0] datPipe_q [DLY];

            always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
                if (aixh_core_rst2x) begin
                    for (int k = 0; k < DLY; k++) begin
                        vldPipe_q[k] <= '0;
                        datPipe_q[k] <= '0;
                    end
                end else begin
                    vldPipe_q[0] <= i_bwd_vld[YCELLS*y +: YCELLS];
                    datPipe_q[0] <= i_bwd_dat[ROW_DW*y +: ROW_DW];
                    for (int k = 1; k < DLY; k++) begin
                        vldPipe_q[k] <= vldPipe_q[k-1];
                        datPipe_q[k] <= datPipe_q[k-1];
                    end
                end
            end

            assign alignVld[YCELLS*y +: YCELLS]    = vldPipe_q[DLY-1];
            assign alignDatRaw[ROW_DW*y +: ROW_DW] = datPipe_q[DLY-1];
        end
    end

    // Cells without a valid carry zero so the consumer never sees stale data.
    for (genvar c = 0; c < NCELL; c++) begin : gCell
        assign alignDat[CELL_DW*c +: CELL_DW] =
            alignVld[c] ? alignDatRaw[CELL_DW*c +: CELL_DW] : '0;
    end

    assign pushVld = |alignVld;

    // Word layout {msk, dat} matches mxc_res_t.
    aixh_mxc_bwd_fifo #(
        .WIDTH    (WORD_W),
        .DEPTH    (FIFO_DEPTH),
        .AFULL_TH (FIFO_DEPTH - YCOUNT)
    ) uFifo (
        .clock_i   (aixh_core_clk2x),
        .reset_i   (aixh_core_rst2x),
        .pushVld_i (pushVld),
        .pushDat_i ({alignVld, alignDat}),
        .popRdy_i  (i_res_rdy),
        .popVld_o  (o_res_vld),
        .popDat_o  (rdWord),
        .afull_o   (o_afull),
        .drop_o    (fifoDrop)
    );

    assign {o_res_msk, o_res_dat} = rdWord;

    // Sticky overflow; a drop in the clearing cycle still leaves it set.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr) begin
            ovf_d = 1'b0;
        end
        if (fifoDrop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
        if (aixh_core_rst2x) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;

`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
    logic              pushAcc;
    logic [STAT_W-1:0] statPush_q, statPush_d;
    logic [STAT_W-1:0] statDrop_q, statDrop_d;

    assign pushAcc = pushVld && !fifoDrop;

    // Saturating word counters; clearing takes priority over counting.
    always_comb begin
        statPush_d = statPush_q;
        statDrop_d = statDrop_q;
        if (i_clr) begin
            statPush_d = '0;
            statDrop_d = '0;
        end else begin
            if (pushAcc && (statPush_q != '1)) begin
                statPush_d = statPush_q + STAT_W'(1);
            end
            if (fifoDrop && (statDrop_q != '1)) begin
                statDrop_d = statDrop_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
        if (aixh_core_rst2x) begin
            statPush_q <= '0;
            statDrop_q <= '0;
        end else begin
            statPush_q <= statPush_d;
            statDrop_q <= statDrop_d;
        end
    end

    assign o_stat_push = statPush_q;
    assign o_stat_drop = statDrop_q;
`endif

endmodule

// File: tb/tb_aixh_mxc_bwd_collect.sv
// ---------------------------------------------------------------------------
// tb_aixh_mxc_bwd_collect
// Directed bench for the backward result collector. Words are issued as
// whole wavefronts; the bench skews them onto the rows and an expected
// word queue stands in for the buffer.
// ---------------------------------------------------------------------------
module tb_aixh_mxc_bwd_collect;
    import AIXH_MXC_pkg::*;

    localparam int YC     = 4;
    localparam int YCELLS = 4;
    localparam int DW     = 32;
    localparam int NC     = YC * YCELLS;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     bwdVld;
    logic [NC*DW-1:0]  bwdDat;
    logic              clr;
    logic              resVld;
    logic              resRdy;
    logic [NC*DW-1:0]  resDat;
    logic [NC-1:0]     resMsk;
    logic              afull;
    logic              ovf;
`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
    logic [31:0]       statPushO;
    logic [31:0]       statDropO;
`endif

    always #5 clk = ~clk;

    aixh_mxc_bwd_collect #(
        .YCOUNT     (YC),
        .YCELLS     (YCELLS),
        .CELL_DW    (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rst2x (rst),
        .i_bwd_vld       (bwdVld),
        .i_bwd_dat       (bwdDat),
        .i_clr           (clr),
        .o_res_vld       (resVld),
        .i_res_rdy       (resRdy),
        .o_res_dat       (resDat),
        .o_res_msk       (resMsk),
        .o_afull         (afull),
        .o_ovf           (ovf)
`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
        ,
        .o_stat_push     (statPushO),
        .o_stat_drop     (statDropO)
`endif
    );

    typedef struct {
        mxc_res_t w;
        int       due;
    } pend_t;

    mxc_res_t expQ [$];
    pend_t    pendQ [$];
    mxc_res_t hist [YC];
    bit       expOvf;
    int       expStatPush;
    int       expStatDrop;
    int       cyc = 0;
    bit       chkEn = 1'b0;
    int       testsRun = 0;
    int       failCount = 0;

    // Every cell carries tag/row/column so misplaced data is visible.
    function automatic mxc_res_t makeWord(input logic [NC-1:0] msk, input int tag);
        mxc_res_t w;
        w.msk = msk;
        for (int y = 0; y < YC; y++) begin
            for (int c = 0; c < YCELLS; c++) begin
                w.dat[(y*YCELLS+c)*DW +: DW] = (tag << 16) | (y << 8) | c;
            end
        end
        return w;
    endfunction

    function automatic mxc_res_t maskWord(input mxc_res_t w);
        mxc_res_t m;
        m = w;
        for (int i = 0; i < NC; i++) begin
            if (!w.msk[i]) m.dat[i*DW +: DW] = '0;
        end
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [NC*DW-1:0] act,
                               input logic [NC*DW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one wavefront: row y shows the word issued y cycles ago.
    task automatic applyStimulus(input mxc_res_t w);
        for (int y = YC - 1; y > 0; y--) hist[y] = hist[y-1];
        hist[0] = w;
        for (int y = 0; y < YC; y++) begin
            bwdVld[y*YCELLS +: YCELLS]       = hist[y].msk[y*YCELLS +: YCELLS];
            bwdDat[y*YCELLS*DW +: YCELLS*DW] = hist[y].dat[y*YCELLS*DW +: YCELLS*DW];
        end
        if (w.msk != '0) begin
            pend_t p;
            p.w   = maskWord(w);
            p.due = cyc + YC - 1;
            pendQ.push_back(p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        bwdVld = '0;
        bwdDat = '0;
        for (int y = 0; y < YC; y++) hist[y] = '0;
        expQ.delete();
        pendQ.delete();
        expOvf      = 1'b0;
        expStatPush = 0;
        expStatDrop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected buffer behaviour: whole words enter YC-1 cycles after issue,
    // the head leaves on ready, a full buffer refuses unless it also pops.
    always @(posedge clk) begin : modelProc
        int nPush;
        int nDrop;
        nPush = 0;
        nDrop = 0;
        if (!rst) begin
            if (expQ.size() > 0 && resRdy) void'(expQ.pop_front());
            while (pendQ.size() > 0 && pendQ[0].due == cyc) begin
                if (expQ.size() < DEPTH) begin
                    expQ.push_back(pendQ[0].w);
                    nPush++;
                end else begin
                    nDrop++;
                end
                void'(pendQ.pop_front());
            end
            if (nDrop > 0) expOvf = 1'b1;
            else if (clr) expOvf = 1'b0;
            if (clr) begin
                expStatPush = 0;
                expStatDrop = 0;
            end else begin
                expStatPush = expStatPush + nPush;
                expStatDrop = expStatDrop + nDrop;
            end
        end
        cyc++;
    end

    // Cycle-by-cycle comparison against the expected queue.
    always @(negedge clk) begin : cmpProc
        mxc_res_t fr;
        if (!rst && chkEn) begin
            fr = '0;
            if (expQ.size() > 0) fr = expQ[0];
            checkOutput("res_vld", resVld, expQ.size() > 0);
            checkOutput("res_msk", resMsk, fr.msk);
            checkOutput("res_dat", resDat, fr.dat);
            checkOutput("afull", afull, expQ.size() >= DEPTH - YC);
            checkOutput("ovf", ovf, expOvf);
`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
            checkOutput("stat_push", statPushO, expStatPush);
            checkOutput("stat_drop", statDropO, expStatDrop);
`endif
        end
    end

    initial begin : stimProc
        logic [NC*DW-1:0] rest;
        int n;
        rst    = 1'b1;
        clr    = 1'b0;
        resRdy = 1'b1;
        bwdVld = '0;
        bwdDat = '0;
        for (int y = 0; y < YC; y++) hist[y] = '0;
        expOvf = 1'b0;
        expStatPush = 0;
        expStatDrop = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_vld", resVld, 0);
        checkOutput("rst_msk", resMsk, 0);
        checkOutput("rst_dat", resDat, 0);
        checkOutput("rst_afull", afull, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst   = 1'b0;
        chkEn = 1'b1;
        idle(2);

        $display("[TB] single burst");
        applyStimulus(makeWord(16'hFFFF, 0));
        idle(2);
        checkOutput("burst_early", resVld, 0);
        idle(1);
        checkOutput("burst_vld", resVld, 1);
        checkOutput("burst_msk", resMsk, 16'hFFFF);
        checkOutput("burst_c0", resDat[0 +: DW], 32'h0);
        checkOutput("burst_c9", resDat[9*DW +: DW], 32'h201);
        checkOutput("burst_c15", resDat[15*DW +: DW], 32'h303);
        idle(2);

        $display("[TB] partial mask");
        applyStimulus(makeWord(16'h0300, 5));
        idle(3);
        checkOutput("part_vld", resVld, 1);
        checkOutput("part_msk", resMsk, 16'h0300);
        checkOutput("part_c8", resDat[8*DW +: DW], 32'h0005_0200);
        checkOutput("part_c9", resDat[9*DW +: DW], 32'h0005_0201);
        rest = resDat;
        rest[8*DW +: 2*DW] = '0;
        checkOutput("part_rest", rest, 0);
        idle(1);
        checkOutput("part_single", resVld, 0);
        idle(2);

        $display("[TB] back-pressure");
        resRdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(makeWord(16'hFFFF, 16 + k));
            checkOutput("bp_afull", afull, k >= 6);
        end
        idle(3);
        checkOutput("bp_ovf", ovf, 1);
        checkOutput("bp_head", resDat[0 +: DW], 32'h0010_0000);

        $display("[TB] full with simultaneous pop");
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        checkOutput("clr_ovf", ovf, 0);
        applyStimulus(makeWord(16'hFFFF, 40));
        idle(2);
        resRdy = 1'b1;
        idle(1);
        resRdy = 1'b0;
        checkOutput("fp_ovf", ovf, 0);
        checkOutput("fp_afull", afull, 1);
        checkOutput("fp_head", resDat[0 +: DW], 32'h0011_0000);
        resRdy = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && resVld; i++) begin
            n++;
            idle(1);
        end
        checkOutput("drain_count", n, 8);

        $display("[TB] reset mid-operation");
        resRdy = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(makeWord(16'hFFFF, 50 + k));
        idle(3);
        applyStimulus(makeWord(16'hFFFF, 60));
        applyStimulus(makeWord(16'hFFFF, 61));
        checkOutput("pre_rst_vld", resVld, 1);
        doReset();
        resRdy = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (resVld) n++;
            idle(1);
        end
        checkOutput("post_rst_quiet", n, 0);

`ifdef AIXH_MXC_BWD_COLLECT_STAT_EN
        $display("[TB] statistics");
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        resRdy = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus(makeWord(16'h00FF, 70 + k));
        idle(3);
        checkOutput("stat_push8", statPushO, 8);
        checkOutput("stat_drop2", statDropO, 2);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        checkOutput("stat_push_clr", statPushO, 0);
        checkOutput("stat_drop_clr", statDropO, 0);
        resRdy = 1'b1;
        idle(10);
`endif

        chkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/aixh_mxc_bwd_collect.md
AIXH_MXC_BWD_COLLECT -- requirements
Module: aixh_mxc_bwd_collect

Interface
REQ-001 SHALL have parameter YCOUNT, default 4: number of tile rows driving the backward result path.
REQ-002 SHALL have parameter YCELLS, default 4: result cells per tile row.
REQ-003 SHALL have parameter CELL_DW, default 32: bits per result cell.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >= 2*YCOUNT): aligned-word buffer depth.
REQ-005 SHALL have port aixh_core_clk2x  in  1  sole clock; every flop on its rising edge.
REQ-006 SHALL have port aixh_core_rst2x  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_bwd_vld  in  YCOUNT*YCELLS  per-cell result valids from the array's west edge; row y occupies bits [YCELLS*y +: YCELLS].
REQ-008 SHALL have port i_bwd_dat  in  YCOUNT*YCELLS*CELL_DW  per-cell result data, same row packing.
REQ-009 SHALL have port i_clr  in  1  synchronous clear of the sticky error and statistics.
REQ-010 SHALL have port o_res_vld  out  1  aligned result word available.
REQ-011 SHALL have port i_res_rdy  in  1  consumer accepts the word.
REQ-012 SHALL have port o_res_dat  out  YCOUNT*YCELLS*CELL_DW  aligned result word.
REQ-013 SHALL have port o_res_msk  out  YCOUNT*YCELLS  per-cell valid mask of the aligned word.
REQ-014 SHALL have port o_afull  out  1  occupancy >= FIFO_DEPTH-YCOUNT; upstream sequencer throttles issue.
REQ-015 SHALL have port o_ovf  out  1  sticky: aligned word dropped because the buffer was full.

Function
REQ-016 SHALL deskew the rows: row y arrives y cycles after row 0 and SHALL be delayed YCOUNT-1-y cycles; row YCOUNT-1 has no delay.
REQ-017 SHALL form the aligned word from delayed rows; mask = aligned valids; data of cells with mask 0 SHALL be zero.
REQ-018 SHALL push the aligned word into a first-word-fall-through FIFO when any mask bit is 1; an all-zero mask is not pushed.
REQ-019 Latency: row 0 presented in cycle t SHALL appear on o_res_vld in cycle t+YCOUNT (empty FIFO, push at the edge closing cycle t+YCOUNT-1).
REQ-020 Pop occurs on o_res_vld && i_res_rdy; o_res_vld, o_res_dat and o_res_msk SHALL stay stable while o_res_vld && !i_res_rdy.
REQ-021 With o_res_vld low, o_res_dat and o_res_msk SHALL be zero.
REQ-022 Push when full without a same-cycle pop SHALL drop the word, set o_ovf and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle when full SHALL accept both; occupancy is unchanged and o_ovf stays clear.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked in log2(FIFO_DEPTH)+1 bits.
REQ-025 i_clr SHALL clear o_ovf next cycle; if i_clr coincides with a drop, o_ovf SHALL be set (set wins).

Reset
REQ-026 On aixh_core_rst2x, deskew registers, FIFO pointers and occupancy SHALL clear; o_res_vld=0, o_res_dat=0, o_res_msk=0, o_afull=0, o_ovf=0.
REQ-027 Reset asserted mid-burst SHALL discard every in-flight and buffered word; nothing emerges after release until new input arrives.

Configuration
REQ-028 With AIXH_MXC_BWD_COLLECT_STAT_EN defined, the block SHALL add outputs o_stat_push (32b, count of pushed words) and o_stat_drop (32b, count of dropped words), both saturating, reset to 0 and cleared by i_clr.
REQ-029 Without AIXH_MXC_BWD_COLLECT_STAT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-030 The cell-width constant and the aligned-word struct (msk, dat) SHALL live in AIXH_MXC_pkg.
REQ-031 The FIFO SHALL be one sub-module, aixh_mxc_bwd_fifo (FWFT, parameterised width and depth); the deskew logic stays in the top module.

Verification
REQ-032 Single burst: row y valid=4'hF, dat=cell index+0x100*y, in cycle t+y; o_res_vld in cycle t+4, msk=16'hFFFF, data matches.
REQ-033 Partial mask: only row 2 cells 0,1 valid; msk=16'h0300, all other data zero, one word pushed.
REQ-034 Back-pressure: i_res_rdy=0, 9 back-to-back words; o_afull rises when occupancy reaches 4, 8 words held, 9th dropped, o_ovf=1; drain yields the first 8 words in order.
REQ-035 Full plus simultaneous pop: FIFO full, i_res_rdy=1 while a new word pushes; occupancy stays 8, o_ovf stays 0.
REQ-036 Reset mid-operation: assert reset with 3 words buffered and 2 in deskew; after release o_res_vld=0 and stays 0 with idle input.
REQ-037 Statistics (STAT_EN): 10 pushes with 2 drops gives o_stat_push=8, o_stat_drop=2; i_clr returns both to 0.
